multi_clock_divider: RTL

Parametrised multi-channel clock-enable generator that replaces ad-hoc free-running divider counters at the system top level. It derives CHANNELS independent slow timing signals (CPU clock, cursor blink, drive timing, etc.) from the single board clock. Each channel has a runtime-programmable divisor and mode. Divisor changes are glitch-free and all channels can be phase-aligned together.

---
 rtl/multi_clock_divider_if.sv | 28 ++
 rtl/multi_clock_divider.sv | 132 +++++++++++++
 2 files changed

// File: rtl/multi_clock_divider_if.sv
// Control/status bundle for multi_clock_divider: run enables, restart strobe,
// divisor/mode programming port, and the per-channel timing outputs.
interface multi_clock_divider_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 32,
    parameter int SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
    logic [CHANNELS-1:0] ChannelEnable;
    logic                SyncRestart;
    logic                WriteEnable;
    logic [SELW-1:0]     WriteChannel;
    logic [WIDTH-1:0]    WriteDivisor;
    logic                WriteMode;
    logic [CHANNELS-1:0] ClockOut;
    logic [CHANNELS-1:0] Tick;
    logic [CHANNELS-1:0] Pending;
    logic [WIDTH-1:0]    ReadDivisor;

    modport master (
        output ChannelEnable, SyncRestart, WriteEnable, WriteChannel, WriteDivisor, WriteMode,
        input  ClockOut, Tick, Pending, ReadDivisor
    );

    modport slave (
        input  ChannelEnable, SyncRestart, WriteEnable, WriteChannel, WriteDivisor, WriteMode,
        output ClockOut, Tick, Pending, ReadDivisor
    );
endinterface

// File: rtl/multi_clock_divider.sv
// Multi-channel clock-enable generator: each lane counts to its divisor and emits
// a Tick plus a square wave or pulse; divisor updates land on terminal count.
module multi_clock_divider_channel #(
    parameter int WIDTH       = 32,
    parameter int DEFAULT_DIV = 50
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             SyncRestart,
    input  logic             Write,
    input  logic [WIDTH-1:0] WriteDivisor,
    input  logic             WriteMode,
    output logic             ClockOut,
    output logic             Tick,
    output logic             Pending,
    output logic [WIDTH-1:0] Divisor
);
    typedef struct packed {
        logic [WIDTH-1:0] div;
        logic             mode;
    } cfg_t;

    cfg_t             active, shadow, incoming;
    logic [WIDTH-1:0] count;
    logic             halted, terminal;

    assign incoming = '{div: WriteDivisor, mode: WriteMode};
    assign halted   = (active.div == '0);
    assign terminal = (count == active.div - 1'b1);
    assign Divisor  = active.div;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            count    <= '0;
            active   <= '{div: WIDTH'(DEFAULT_DIV), mode: 1'b0};
            shadow   <= '{div: WIDTH'(DEFAULT_DIV), mode: 1'b0};
            Pending  <= 1'b0;
            ClockOut <= 1'b0;
            Tick     <= 1'b0;
        end else if (SyncRestart) begin
            // A same-edge write beats any older shadow value.
            count    <= '0;
            ClockOut <= 1'b0;
            Tick     <= 1'b0;
            Pending  <= 1'b0;
            if (Write)        active <= incoming;
            else if (Pending) active <= shadow;
        end else if (Write && (!Enable || halted)) begin
            // Nothing is running, so the new setting can take effect now.
            active  <= incoming;
            Pending <= 1'b0;
            count   <= '0;
            Tick    <= 1'b0;
            if (halted || active.mode) ClockOut <= 1'b0;
        end else if (halted) begin
            count    <= '0;
            Tick     <= 1'b0;
            ClockOut <= 1'b0;
        end else if (!Enable) begin
            Tick <= 1'b0;
            if (active.mode) ClockOut <= 1'b0;
        end else if (terminal) begin
            // Outputs follow the outgoing mode; the committed divisor governs the next period.
            count    <= '0;
            Tick     <= 1'b1;
            ClockOut <= active.mode ? 1'b1 : ~ClockOut;
            Pending  <= 1'b0;
            if (Write)        active <= incoming;
            else if (Pending) active <= shadow;
        end else begin
            count <= count + 1'b1;
            Tick  <= 1'b0;
            if (active.mode) ClockOut <= 1'b0;
            if (Write) begin
                shadow  <= incoming;
                Pending <= 1'b1;
            end
        end
    end
endmodule

module multi_clock_divider #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 32,
    parameter int DEFAULT_DIV = 50,
    parameter int SELW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 Clock,
    input  logic                 Reset,
    multi_clock_divider_if.slave bus
);
    logic [CHANNELS-1:0]            writeHit, clockOut, tick, pending;
    logic [CHANNELS-1:0][WIDTH-1:0] divisor;
    logic                           selValid;
    logic [WIDTH-1:0]               readDivisor;

    assign selValid = ({1'b0, bus.WriteChannel} < (SELW+1)'(CHANNELS));

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
            assign writeHit[i] = bus.WriteEnable && (bus.WriteChannel == SELW'(i));

            multi_clock_divider_channel #(
                .WIDTH       (WIDTH),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_chan (
                .Clock        (Clock),
                .Reset        (Reset),
                .Enable       (bus.ChannelEnable[i]),
                .SyncRestart  (bus.SyncRestart),
                .Write        (writeHit[i]),
                .WriteDivisor (bus.WriteDivisor),
                .WriteMode    (bus.WriteMode),
                .ClockOut     (clockOut[i]),
                .Tick         (tick[i]),
                .Pending      (pending[i]),
                .Divisor      (divisor[i])
            );
        end
    endgenerate

    always_comb begin
        readDivisor = '0;
        if (selValid) readDivisor = divisor[bus.WriteChannel];
    end

    assign bus.ClockOut    = clockOut;
    assign bus.Tick        = tick;
    assign bus.Pending     = pending;
    assign bus.ReadDivisor = readDivisor;
endmodule
